rv32e_data_bus: RTL and testbench
=================================

# rv32e_data_bus

Data-side memory subsystem sitting directly downstream of the rv32e_cpu data port. It consumes `mem_addr_bus`, `mem_write_data_bus` and `mem_write_signal`, and returns `mem_read_data_bus`. It decodes a 32-bit address into four targets:
- a word RAM;
- a GPIO output register;
- a free-running cycle counter;
- a UART transmitter with a 4-entry byte FIFO.

## Interface
- `RAM_ADDR_W`, default 10: RAM word-index width (1024 words = 4 KiB).
- `CLKS_PER_BIT`, default 16: clocks per UART bit (legal range ≥ 2).
- `GPIO_W`, default 8: width of the GPIO output.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `mem_addr_bus`, in, 32: byte address. `addr[1:0]` is ignored (word access only).
- `mem_write_data_bus`, in, 32: write data.
- `mem_write_signal`, in, 1: write strobe. Each rising edge with it high performs one write.
- `mem_read_data_bus`, out, 32: read data.
- `gpio_out`, out, `GPIO_W`: GPIO register.
- `uart_tx`, out, 1: serial output. Idle level is 1.

## Operation
- **Address map**, decoded on `addr[31:2]`:
  - `addr[31:28]`=0x0 → RAM, index `addr[RAM_ADDR_W+1:2]`. Higher bits alias (wrap).
  - 0x8000_0000 GPIO: R/W. Read returns `gpio_out` zero-extended. Write sets `gpio_out` ← `data[GPIO_W-1:0]`.
  - 0x8000_0004 CYCLE: read-only, 32-bit, increments every clock, wraps 0xFFFF_FFFF→0. Writes are ignored.
  - 0x8000_0008 TXDATA: write pushes `data[7:0]` into the FIFO. Read returns 0.
  - 0x8000_000C STATUS: read returns `{25'b0, count[2:0], overflow, empty, full, busy}` in bits `[6:4]`, 3, 2, 1, 0 order. Any write clears `overflow`.
  - Any other address: read returns 0, write is ignored.
- **Reads** are combinational from `mem_addr_bus` and current state. The CPU latches read data one cycle after presenting the address, so registered read data is forbidden. Reads have no side effects.
- **Reset values:**
  - `gpio_out`=0, CYCLE=0, FIFO empty (count=0), `overflow`=0.
  - TX FSM in IDLE, `uart_tx`=1.
  - RAM contents are not reset.
  - Reset asserted mid-frame aborts the frame immediately and forces `uart_tx`=1.
- **FIFO:** depth 4, circular with 2-bit read/write pointers plus a 3-bit count.
  - A push is accepted if count<4 before the edge, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and `overflow` is set (sticky).
  - Simultaneous push and pop leaves count unchanged.
  - Simultaneous overflow-push and STATUS-write is impossible, since there is one address per cycle.
- **TX FSM:** states IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop the head into the shift register and go to START.
  - START: drive `uart_tx`=0 for `CLKS_PER_BIT` clocks, then go to DATA.
  - DATA: drive 8 bits, LSB first, each for `CLKS_PER_BIT` clocks (bit counter 0..7), then go to STOP.
  - STOP: drive `uart_tx`=1 for `CLKS_PER_BIT` clocks, then go to IDLE.
  - `busy` = state≠IDLE.
  - `uart_tx` is registered (glitch-free).

## Timing
- **Write:** committed at the rising edge where `mem_write_signal`=1. A read of the same address in the following cycle returns the new value.
- **Read:** valid within the same cycle the address is stable.
- **TX latency:**
  - TXDATA write at edge T with FIFO empty and FSM idle.
  - Pop and START entry at edge T+1; `uart_tx` falls after edge T+1.
  - The frame lasts exactly 10×`CLKS_PER_BIT` clocks.
  - FSM spends exactly one IDLE cycle between back-to-back frames.
- **STATUS timing:** `count` and `full` reflect the FIFO after the most recent edge. `busy` is 1 from edge T+1 to the end of STOP.
- **CYCLE** reads N at cycle N after reset release (first edge after release → 1).

## Test plan
- **Reset:** hold `reset`=0 across edges, release → `uart_tx`=1, `gpio_out`=0, STATUS=0x0000_0004; CYCLE read reads 0 before the first post-reset edge. Assert reset mid-frame → `uart_tx`=1 immediately, STATUS=0x4.
- **RAM:**
  - Write 0xDEAD_BEEF at 0x0000_0010, read 0x0000_0010 → 0xDEAD_BEEF.
  - Read 0x0000_1010 (alias, `RAM_ADDR_W`=10) → 0xDEAD_BEEF.
  - Read 0x0000_0013 → 0xDEAD_BEEF.
  - Read 0x4000_0000 → 0.
- **GPIO/CYCLE:**
  - Write 0x1234_56A5 to GPIO → `gpio_out`=0xA5, read → 0x0000_00A5.
  - Write CYCLE → value is unchanged.
  - Two CYCLE reads 5 clocks apart differ by 5.
- **UART single byte** (`CLKS_PER_BIT`=4): write 0x55 to TXDATA.
  - `uart_tx` sequence is 0,1,0,1,0,1,0,1,0,1, each bit held 4 clocks, starting one edge after the write.
  - STATUS `busy`=1 for 40 clocks.
- **FIFO full/overflow:**
  - Write 0x01..0x06 on consecutive cycles while idle.
  - The first byte is popped at T+1, so 0x01..0x05 are accepted.
  - STATUS shows `full`=1, count=4, then the 0x06 push is dropped and `overflow`=1.
  - Write STATUS → `overflow`=0.
  - Serial output shows bytes 01,02,03,04,05 in order with a 1-clock idle gap between frames.
- **Push-with-pop:** fill the FIFO to 4 while busy, then write TXDATA on the exact edge IDLE pops → byte accepted, count stays 4, `overflow` stays 0.

Source files
------------

// File: rtl/rv32e_data_bus.sv
// Data-side memory subsystem for the rv32e core: word RAM, GPIO register,
// free-running cycle counter and a FIFO-buffered UART transmitter.
module rv32e_data_bus #(
    parameter int RAM_ADDR_W   = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int GPIO_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_addr_bus,
    input  logic [31:0]       mem_write_data_bus,
    input  logic              mem_write_signal,
    output logic [31:0]       mem_read_data_bus,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              uart_tx
);

    // state    | meaning
    // S_IDLE   | line high, pops FIFO head when one is waiting
    // S_START  | start bit (low) for CLKS_PER_BIT clocks
    // S_DATA   | 8 data bits, LSB first, CLKS_PER_BIT clocks each
    // S_STOP   | stop bit (high) for CLKS_PER_BIT clocks
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam int RAM_WORDS = 1 << RAM_ADDR_W;

    logic [29:0] word_addr;
    logic        sel_ram, sel_gpio, sel_cycle, sel_txdata, sel_status;
    logic        wr;
    logic [RAM_ADDR_W-1:0] ram_idx;

    logic [31:0] ram_mem [RAM_WORDS];

    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [31:0]       cycle_q, cycle_d;
    logic [7:0]        fifo_q [4];
    logic [7:0]        fifo_d [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic              overflow_q, overflow_d;

    tx_state_e         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic pop, push_req, push_ok, fifo_full, fifo_empty, busy, timer_tc;
    logic unused_addr_bits;

    assign word_addr  = mem_addr_bus[31:2];
    assign sel_ram    = (mem_addr_bus[31:28] == 4'h0);
    assign sel_gpio   = (word_addr == 30'h2000_0000);
    assign sel_cycle  = (word_addr == 30'h2000_0001);
    assign sel_txdata = (word_addr == 30'h2000_0002);
    assign sel_status = (word_addr == 30'h2000_0003);
    assign wr         = mem_write_signal;
    assign ram_idx    = mem_addr_bus[RAM_ADDR_W+1:2];

    assign unused_addr_bits = ^mem_addr_bus[1:0];

    assign fifo_full  = (count_q == 3'd4);
    assign fifo_empty = (count_q == 3'd0);
    assign busy       = (state_q != S_IDLE);
    assign timer_tc   = (timer_q == '0);

    assign gpio_out = gpio_q;
    assign uart_tx  = tx_q;

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (wr && sel_ram) begin
            ram_mem[ram_idx] <= mem_write_data_bus;
        end
    end

    always_comb begin
        mem_read_data_bus = '0;
        if (sel_ram) begin
            mem_read_data_bus = ram_mem[ram_idx];
        end else if (sel_gpio) begin
            mem_read_data_bus = 32'(gpio_q);
        end else if (sel_cycle) begin
            mem_read_data_bus = cycle_q;
        end else if (sel_status) begin
            mem_read_data_bus = {25'b0, count_q, overflow_q, fifo_empty, fifo_full, busy};
        end
    end

    always_comb begin
        gpio_d = gpio_q;
        if (wr && sel_gpio) begin
            gpio_d = mem_write_data_bus[GPIO_W-1:0];
        end
        cycle_d = cycle_q + 32'd1;

        // A full FIFO still takes a byte when the TX side drains one on the same edge.
        push_req = wr && sel_txdata;
        push_ok  = push_req && (!fifo_full || pop);

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = mem_write_data_bus[7:0];
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b0, push_ok} - {2'b0, pop};

        overflow_d = overflow_q;
        if (wr && sel_status) begin
            overflow_d = 1'b0;
        end else if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_q[rd_ptr_q];
                    timer_d = BIT_LAST;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_tc) begin
                    state_d   = S_DATA;
                    timer_d   = BIT_LAST;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DATA: begin
                if (timer_tc) begin
                    timer_d = BIT_LAST;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_STOP: begin
                if (timer_tc) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q     <= '0;
            cycle_q    <= '0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            gpio_q     <= gpio_d;
            cycle_q    <= cycle_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_rv32e_data_bus.sv
// Bench for rv32e_data_bus: directed and random bus traffic compared against
// a queue-based model of the address map, FIFO and serial waveform.
module tb_rv32e_data_bus;

    localparam int CPB = 4;
    localparam logic [31:0] A_GPIO = 32'h8000_0000;
    localparam logic [31:0] A_CYC  = 32'h8000_0004;
    localparam logic [31:0] A_TX   = 32'h8000_0008;
    localparam logic [31:0] A_ST   = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_addr_bus = '0;
    logic [31:0] mem_write_data_bus = '0;
    logic        mem_write_signal = 1'b0;
    logic [31:0] mem_read_data_bus;
    logic [7:0]  gpio_out;
    logic        uart_tx;

    rv32e_data_bus #(.RAM_ADDR_W(10), .CLKS_PER_BIT(CPB), .GPIO_W(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_addr_bus       (mem_addr_bus),
        .mem_write_data_bus (mem_write_data_bus),
        .mem_write_signal   (mem_write_signal),
        .mem_read_data_bus  (mem_read_data_bus),
        .gpio_out           (gpio_out),
        .uart_tx            (uart_tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: bytes waiting, line levels still to be sent, registers.
    logic [7:0]  q_m[$];
    logic        wave_m[$];
    logic        busy_m = 1'b0;
    logic        tx_m   = 1'b1;
    logic        ovf_m  = 1'b0;
    logic [7:0]  gpio_m = '0;
    logic [31:0] cycle_m = '0;
    logic [31:0] ram_m [int];
    logic [31:0] last_status;
    int          busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_m();
        int sz = q_m.size();
        return {25'b0, 3'(sz), ovf_m, (sz == 0), (sz == 4), busy_m};
    endfunction

    task automatic model_reset();
        q_m.delete();
        wave_m.delete();
        busy_m  = 1'b0;
        tx_m    = 1'b1;
        ovf_m   = 1'b0;
        gpio_m  = '0;
        cycle_m = '0;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [31:0] wa;
        logic        popped;
        wa = a & ~32'h3;
        cycle_m = cycle_m + 32'd1;
        popped = !busy_m && (q_m.size() != 0);
        if (popped) begin
            b = q_m.pop_front();
            for (int k = 0; k < CPB; k++) wave_m.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < CPB; k++) wave_m.push_back(b[i]);
            for (int k = 0; k < CPB; k++) wave_m.push_back(1'b1);
        end
        if (we) begin
            if (a[31:28] == 4'h0) ram_m[int'((a >> 2) & 32'h3FF)] = d;
            else if (wa == A_GPIO) gpio_m = d[7:0];
            else if (wa == A_TX) begin
                if (q_m.size() < 4) q_m.push_back(d[7:0]);
                else ovf_m = 1'b1;
            end else if (wa == A_ST) ovf_m = 1'b0;
        end
        if (wave_m.size() != 0) begin
            tx_m   = wave_m.pop_front();
            busy_m = 1'b1;
        end else begin
            tx_m   = 1'b1;
            busy_m = 1'b0;
        end
    endtask

    task automatic tick(input logic we, input logic [31:0] a, input logic [31:0] d);
        mem_write_signal   = we;
        mem_addr_bus       = a;
        mem_write_data_bus = d;
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        mem_write_signal = 1'b0;
        chk("uart_tx", {31'b0, uart_tx}, {31'b0, tx_m});
        chk("gpio_out", {24'b0, gpio_out}, {24'b0, gpio_m});
        mem_addr_bus = A_ST;
        #1;
        last_status = mem_read_data_bus;
        busy_cnt += int'(last_status[0]);
        chk("status", last_status, status_m());
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_write_signal = 1'b0;
        mem_addr_bus     = a;
        #1;
        chk(tag, mem_read_data_bus, exp);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy_m || q_m.size() != 0) && n < 2000) begin
            tick(1'b0, 32'h0, 32'h0);
            n++;
        end
        chk("drain_bound", {31'b0, (busy_m || q_m.size() != 0)}, 32'h0);
    endtask

    initial begin
        logic [31:0] v1, v2, a, d;
        logic [7:0]  b;
        int          idxs[$];
        int          idx;

        // Reset and post-release state before the first edge
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        mem_addr_bus = A_ST;
        #1;
        chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
        chk("rst_gpio", {24'b0, gpio_out}, 32'h0);
        chk("rst_status", mem_read_data_bus, 32'h4);
        rd("rst_cycle", A_CYC, 32'h0);

        // RAM directed
        tick(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
        rd("ram_lowbits", 32'h0000_0013, 32'hDEAD_BEEF);
        rd("unmapped_4000", 32'h4000_0000, 32'h0);
        rd("unmapped_8010", 32'h8000_0010, 32'h0);

        // RAM random with random alias bits
        for (int i = 0; i < 16; i++) begin
            idx = int'($urandom_range(0, 1023));
            a = ($urandom & 32'h0FFF_F000) | (32'(idx) << 2) | ($urandom & 32'h3);
            tick(1'b1, a, $urandom);
            idxs.push_back(idx);
        end
        foreach (idxs[i]) begin
            a = ($urandom & 32'h0FFF_F000) | (32'(idxs[i]) << 2) | ($urandom & 32'h3);
            rd("ram_rand", a, ram_m[idxs[i]]);
            tick(1'b0, 32'h0, 32'h0);
        end

        // GPIO
        tick(1'b1, A_GPIO, 32'h1234_56A5);
        chk("gpio_a5", {24'b0, gpio_out}, 32'hA5);
        rd("gpio_rd", A_GPIO, 32'h0000_00A5);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, A_GPIO | ($urandom & 32'h3), $urandom);
            rd("gpio_rand", A_GPIO, {24'b0, gpio_m});
        end

        // CYCLE
        rd("cycle_now", A_CYC, cycle_m);
        tick(1'b1, A_CYC, $urandom);
        rd("cycle_wr_ignored", A_CYC, cycle_m);
        rd("txdata_rd_zero", A_TX, 32'h0);
        mem_addr_bus = A_CYC;
        #1 v1 = mem_read_data_bus;
        repeat (5) tick(1'b0, 32'h0, 32'h0);
        rd("cycle_after5", A_CYC, cycle_m);
        v2 = mem_read_data_bus;
        chk("cycle_delta5", v2 - v1, 32'd5);

        // Single byte 0x55
        busy_cnt = 0;
        tick(1'b1, A_TX, 32'h0000_0055);
        drain();
        chk("busy_clocks", 32'(busy_cnt), 32'd40);

        // FIFO fill and overflow
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, A_TX, 32'(i));
            if (i == 5) chk("fifo_full_st", last_status, 32'h43);
        end
        chk("fifo_ovf_st", last_status, 32'h4B);
        tick(1'b1, A_ST, $urandom);
        chk("ovf_clear_st", last_status, 32'h43);
        drain();

        // Push on the exact edge where IDLE pops
        for (int i = 0; i < 5; i++) tick(1'b1, A_TX, 32'h0000_00A0 + 32'(i));
        chk("pwp_pre_st", last_status, 32'h43);
        begin
            int n = 0;
            while (busy_m && n < 100) begin
                tick(1'b0, 32'h0, 32'h0);
                n++;
            end
        end
        chk("pwp_idle_gap", last_status, 32'h42);
        tick(1'b1, A_TX, 32'h0000_00F5);
        chk("pwp_post_st", last_status, 32'h43);
        drain();

        // Random bytes with random gaps
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            tick(1'b1, A_TX, {24'($urandom), b});
            repeat ($urandom_range(0, 45)) tick(1'b0, 32'h0, 32'h0);
        end
        drain();

        // Reset mid-frame
        tick(1'b1, A_GPIO, 32'h0000_003C);
        tick(1'b1, A_TX, 32'h0000_0000);
        repeat (15) tick(1'b0, 32'h0, 32'h0);
        chk("pre_rst_low", {31'b0, uart_tx}, 32'h0);
        reset = 1'b0;
        mem_addr_bus = A_ST;
        #1;
        chk("midrst_uart_tx", {31'b0, uart_tx}, 32'h1);
        chk("midrst_status", mem_read_data_bus, 32'h4);
        chk("midrst_gpio", {24'b0, gpio_out}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rd("midrst_cycle", A_CYC, 32'h0);
        tick(1'b1, A_TX, 32'h0000_00C3);
        drain();
        rd("final_cycle", A_CYC, cycle_m);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
